// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: memory geometry and loader FSM states.
package imem_pkg;

    localparam int IMEM_ADDR_W = 13;
    localparam int IMEM_DEPTH  = 8192;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and pulses word_valid
// for one cycle after the fourth byte of each word.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic [1:0]  lane,
    output logic [31:0] word,
    output logic        word_valid
);

    // The full word stays in the assembly register during the word_valid cycle;
    // the next word's first byte only overwrites it on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane       <= 2'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= 2'd0;
                word <= 32'd0;
            end else if (in_valid) begin
                word[{lane, 3'b000} +: 8] <= in_byte;
                lane                      <= lane + 2'd1;
                word_valid                <= (lane == 2'd3);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: 16-bit word-count header, little-endian payload packing,
// sequential instruction-memory writes. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int MAX_WORDS = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_PAYLOAD = CSUM;
`else
    localparam loader_state_t AFTER_PAYLOAD = DONE;
`endif

    loader_state_t     state, state_next;
    logic [7:0]        count_lo;
    logic [15:0]       count;
    logic [15:0]       word_cnt;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       hdr_count;
    logic              start_acc;
    logic              accept;
    logic              last_word;
    logic [1:0]        lane;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign start_acc = start && (state == IDLE || state == DONE || state == ERR);
    assign accept    = in_valid && in_ready;
    assign hdr_count = {in_data, count_lo};
    assign last_word = (word_cnt + 16'd1) == count;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_acc),
        .in_byte    (in_data),
        .in_valid   (accept && state == DATA),
        .lane       (lane),
        .word       (mem_wdata),
        .word_valid (mem_we)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: if (start) state_next = HDR0;
            HDR0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_next = HDR1;
            end
            HDR1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (hdr_count == 16'd0)                 state_next = AFTER_PAYLOAD;
                    else if (hdr_count > 16'(MAX_WORDS))    state_next = ERR;
                    else                                    state_next = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && lane == 2'd3 && last_word) state_next = AFTER_PAYLOAD;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_next = (in_data == csum) ? DONE : ERR;
            end
`endif
            DONE, ERR: if (start) state_next = HDR0;
            default: state_next = IDLE;
        endcase
    end

    // Address advances at the end of each write cycle, so mem_addr is stable while mem_we is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_lo <= 8'd0;
            count    <= 16'd0;
            word_cnt <= 16'd0;
            addr     <= '0;
        end else if (start_acc) begin
            word_cnt <= 16'd0;
            addr     <= '0;
        end else begin
            if (accept && state == HDR0) count_lo <= in_data;
            if (accept && state == HDR1) count    <= hdr_count;
            if (accept && state == DATA && lane == 2'd3) word_cnt <= word_cnt + 16'd1;
            if (mem_we) addr <= addr + 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            csum <= 8'd0;
        else if (start_acc)                 csum <= 8'd0;
        else if (accept && state == DATA)   csum <= csum ^ in_data;
    end
`endif

    assign mem_addr = addr;
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign cpu_hold = (state != DONE);

endmodule
